// File: rtl/pspin_ctrl_axil_master.sv
// AXI-Lite initiator for the PsPIN control register file.
// Turns single write / read / poll-until-match commands into AXI-Lite transactions
// and returns exactly one response per command. One command is in flight at a time.

module pspin_ctrl_axil_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int POLL_INTERVAL  = 16,
   parameter int POLL_MAX_TRIES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,

   // Command port
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic [DATA_WIDTH-1:0] cmd_mask,

   // Response port
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [1:0]            rsp_status,

   // AXI-Lite write address channel
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,

   // AXI-Lite write data channel
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,

   // AXI-Lite write response channel
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,

   // AXI-Lite read address channel
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,

   // AXI-Lite read data channel
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_POLL  = 2'd2;

   localparam logic [1:0] STATUS_OKAY    = 2'd0;
   localparam logic [1:0] STATUS_SLVERR  = 2'd1;
   localparam logic [1:0] STATUS_TIMEOUT = 2'd2;

   localparam int TRY_W  = $clog2(POLL_MAX_TRIES + 1);
   localparam int WAIT_W = $clog2(POLL_INTERVAL + 1);

   localparam logic [TRY_W-1:0]  TRIES_MAX = TRY_W'(POLL_MAX_TRIES);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POLL_INTERVAL - 1);

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StWrResp,
      StRdAddr,
      StRdData,
      StPollWait,
      StResp
   } state_e;

   state_e                state_q;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] mask_q;
   logic [TRY_W-1:0]      tries_q;
   logic [WAIT_W-1:0]     wait_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  b_hs;
   logic                  ar_hs;
   logic                  r_hs;
   logic                  poll_match;
   logic [TRY_W-1:0]      tries_inc;

   // Request fields come straight from the latched command
   assign m_axil_awaddr = addr_q;
   assign m_axil_araddr = addr_q;
   assign m_axil_wdata  = data_q;
   assign m_axil_wstrb  = '1;
   assign m_axil_awprot = 3'b000;
   assign m_axil_arprot = 3'b000;

   assign aw_hs = m_axil_awvalid & m_axil_awready;
   assign w_hs  = m_axil_wvalid  & m_axil_wready;
   assign b_hs  = m_axil_bvalid  & m_axil_bready;
   assign ar_hs = m_axil_arvalid & m_axil_arready;
   assign r_hs  = m_axil_rvalid  & m_axil_rready;

   // Poll compares only the masked bits; a zero mask always matches
   assign poll_match = ((m_axil_rdata & mask_q) == (data_q & mask_q));

   // Saturating try counter, value after counting the current read
   assign tries_inc = (tries_q == '1) ? tries_q : tries_q + TRY_W'(1);

   // Command sequencer: state, AXI handshakes and registered response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         cmd_ready      <= 1'b1;
         rsp_valid      <= 1'b0;
         rsp_data       <= '0;
         rsp_status     <= STATUS_OKAY;
         m_axil_awvalid <= 1'b0;
         m_axil_wvalid  <= 1'b0;
         m_axil_bready  <= 1'b0;
         m_axil_arvalid <= 1'b0;
         m_axil_rready  <= 1'b0;
         op_q           <= OP_WRITE;
         addr_q         <= '0;
         data_q         <= '0;
         mask_q         <= '0;
         tries_q        <= '0;
         wait_q         <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  op_q      <= cmd_op;
                  addr_q    <= cmd_addr;
                  data_q    <= cmd_data;
                  mask_q    <= cmd_mask;
                  tries_q   <= '0;
                  wait_q    <= '0;
                  if (cmd_op == OP_WRITE) begin
                     m_axil_awvalid <= 1'b1;
                     m_axil_wvalid  <= 1'b1;
                     state_q        <= StWr;
                  end else begin
                     // Reserved op is handled as a plain read
                     m_axil_arvalid <= 1'b1;
                     state_q        <= StRdAddr;
                  end
               end
            end

            StWr: begin
               if (aw_hs) begin
                  m_axil_awvalid <= 1'b0;
               end
               if (w_hs) begin
                  m_axil_wvalid <= 1'b0;
               end
               // A dropped valid means that channel already completed
               if ((aw_hs || !m_axil_awvalid) && (w_hs || !m_axil_wvalid)) begin
                  m_axil_bready <= 1'b1;
                  state_q       <= StWrResp;
               end
            end

            StWrResp: begin
               if (b_hs) begin
                  m_axil_bready <= 1'b0;
                  rsp_valid     <= 1'b1;
                  rsp_data      <= '0;
                  rsp_status    <= (m_axil_bresp != 2'b00) ? STATUS_SLVERR : STATUS_OKAY;
                  state_q       <= StResp;
               end
            end

            StRdAddr: begin
               if (ar_hs) begin
                  m_axil_arvalid <= 1'b0;
                  m_axil_rready  <= 1'b1;
                  state_q        <= StRdData;
               end
            end

            StRdData: begin
               if (r_hs) begin
                  m_axil_rready <= 1'b0;
                  rsp_data      <= m_axil_rdata;
                  if (op_q == OP_POLL) begin
                     tries_q <= tries_inc;
                     if (m_axil_rresp != 2'b00) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= STATUS_SLVERR;
                        state_q    <= StResp;
                     end else if (poll_match) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= STATUS_OKAY;
                        state_q    <= StResp;
                     end else if (tries_inc == TRIES_MAX) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= STATUS_TIMEOUT;
                        state_q    <= StResp;
                     end else begin
                        wait_q  <= '0;
                        state_q <= StPollWait;
                     end
                  end else begin
                     rsp_valid  <= 1'b1;
                     rsp_status <= (m_axil_rresp != 2'b00) ? STATUS_SLVERR : STATUS_OKAY;
                     state_q    <= StResp;
                  end
               end
            end

            StPollWait: begin
               if (wait_q == WAIT_LAST) begin
                  wait_q         <= '0;
                  m_axil_arvalid <= 1'b1;
                  state_q        <= StRdAddr;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end

            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state_q   <= StIdle;
               end
            end

            default: begin
               m_axil_awvalid <= 1'b0;
               m_axil_wvalid  <= 1'b0;
               m_axil_bready  <= 1'b0;
               m_axil_arvalid <= 1'b0;
               m_axil_rready  <= 1'b0;
               rsp_valid      <= 1'b0;
               cmd_ready      <= 1'b1;
               state_q        <= StIdle;
            end
         endcase
      end
   end

   // Valids are never withdrawn before their handshake
   a_awvalid_hold : assert property (@(posedge clk) disable iff (rst)
      m_axil_awvalid && !m_axil_awready |=> m_axil_awvalid);
   a_wvalid_hold  : assert property (@(posedge clk) disable iff (rst)
      m_axil_wvalid && !m_axil_wready |=> m_axil_wvalid);
   a_arvalid_hold : assert property (@(posedge clk) disable iff (rst)
      m_axil_arvalid && !m_axil_arready |=> m_axil_arvalid);
   a_rsp_hold     : assert property (@(posedge clk) disable iff (rst)
      rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_data) && $stable(rsp_status));

endmodule

// File: tb/tb_pspin_ctrl_axil_master.sv
// Self-checking bench for pspin_ctrl_axil_master: scriptable AXI-Lite slave model,
// expected-response scoreboard and a monitor that checks every presented response.

module tb_pspin_ctrl_axil_master;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int PI  = 4;
   localparam int PMT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data, cmd_mask;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_status;

   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp, rresp;

   pspin_ctrl_axil_master #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .STRB_WIDTH     (SW),
      .POLL_INTERVAL  (PI),
      .POLL_MAX_TRIES (PMT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_addr       (cmd_addr),
      .cmd_data       (cmd_data),
      .cmd_mask       (cmd_mask),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .rsp_status     (rsp_status),
      .m_axil_awaddr  (awaddr),
      .m_axil_awprot  (awprot),
      .m_axil_awvalid (awvalid),
      .m_axil_awready (awready),
      .m_axil_wdata   (wdata),
      .m_axil_wstrb   (wstrb),
      .m_axil_wvalid  (wvalid),
      .m_axil_wready  (wready),
      .m_axil_bresp   (bresp),
      .m_axil_bvalid  (bvalid),
      .m_axil_bready  (bready),
      .m_axil_araddr  (araddr),
      .m_axil_arprot  (arprot),
      .m_axil_arvalid (arvalid),
      .m_axil_arready (arready),
      .m_axil_rdata   (rdata),
      .m_axil_rresp   (rresp),
      .m_axil_rvalid  (rvalid),
      .m_axil_rready  (rready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    status;
      int            lat;
      string         name;
   } exp_t;

   exp_t exp_q[$];
   int   rsp_cnt    = 0;
   int   accept_cyc = 0;
   int   hold_len   = 0;
   int   rsp_start  = 0;
   bit   in_rsp     = 1'b0;

   // Monitor: compares every cycle a response is presented, pops on acceptance
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            in_rsp = 1'b0;
         end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rsp: got data 0x%0h status %0d, expected no response",
                        rsp_data, rsp_status);
            end else begin
               if (!in_rsp) begin
                  in_rsp    = 1'b1;
                  rsp_start = cyc;
                  if (exp_q[0].lat >= 0)
                     check({exp_q[0].name, "_latency"}, 64'(cyc - accept_cyc), 64'(exp_q[0].lat));
               end
               check({exp_q[0].name, "_data"}, 64'(rsp_data), 64'(exp_q[0].data));
               check({exp_q[0].name, "_status"}, 64'(rsp_status), 64'(exp_q[0].status));
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  rsp_cnt++;
                  hold_len = cyc - rsp_start + 1;
                  in_rsp   = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- AXI-Lite slave model ----------------
   int            cfg_aw_delay = 0, cfg_w_delay = 0, cfg_ar_delay = 0, cfg_r_delay = 0;
   int            cfg_rsp_hold = 0;
   logic [1:0]    cfg_bresp = 2'd0, cfg_rresp = 2'd0;
   logic [DW-1:0] cfg_rdata_def = '0;
   logic [DW-1:0] rdq[$];

   int            aw_count = 0, w_count = 0, b_count = 0, ar_count = 0;
   int            last_ar_cyc = 0, min_ar_gap = 1000;
   bit            gap_armed = 1'b0;
   logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
   logic [DW-1:0] last_wdata = '0;
   logic [SW-1:0] last_wstrb = '0;

   bit aw_hs_f, w_hs_f, b_hs_f, ar_hs_f, r_hs_f, aw_seen, w_seen, r_pend;
   int aw_wt, w_wt, ar_wt, r_wt, rsp_wt;

   // Inputs change only at negedge; handshakes noted here complete at the next posedge
   initial begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = '0; rresp = 0; rsp_ready = 0;
      aw_hs_f = 0; w_hs_f = 0; b_hs_f = 0; ar_hs_f = 0; r_hs_f = 0;
      aw_seen = 0; w_seen = 0; r_pend = 0;
      aw_wt = 0; w_wt = 0; ar_wt = 0; r_wt = 0; rsp_wt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rsp_ready = 0;
            aw_hs_f = 0; w_hs_f = 0; b_hs_f = 0; ar_hs_f = 0; r_hs_f = 0;
            aw_seen = 0; w_seen = 0; r_pend = 0;
            aw_wt = 0; w_wt = 0; ar_wt = 0; r_wt = 0; rsp_wt = 0;
         end else begin
            if (aw_hs_f) begin aw_seen = 1; aw_count++; end
            if (w_hs_f)  begin w_seen = 1; w_count++; end
            if (b_hs_f)  begin bvalid = 0; b_count++; end
            if (ar_hs_f) begin
               ar_count++;
               if (gap_armed && (cyc - last_ar_cyc) < min_ar_gap) min_ar_gap = cyc - last_ar_cyc;
               gap_armed   = 1;
               last_ar_cyc = cyc;
               r_pend      = 1;
               r_wt        = 0;
            end
            if (r_hs_f) rvalid = 0;
            if (aw_seen && w_seen) begin
               aw_seen = 0; w_seen = 0; bvalid = 1; bresp = cfg_bresp;
            end
            if (r_pend) begin
               if (r_wt >= cfg_r_delay) begin
                  r_pend = 0; rvalid = 1; rresp = cfg_rresp;
                  if (rdq.size() > 0) rdata = rdq.pop_front();
                  else rdata = cfg_rdata_def;
               end else begin
                  r_wt++;
               end
            end
            awready = awvalid && (aw_wt >= cfg_aw_delay);
            if (awvalid && !awready) aw_wt++; else aw_wt = 0;
            wready = wvalid && (w_wt >= cfg_w_delay);
            if (wvalid && !wready) w_wt++; else w_wt = 0;
            arready = arvalid && (ar_wt >= cfg_ar_delay);
            if (arvalid && !arready) ar_wt++; else ar_wt = 0;
            if (rsp_valid) begin
               rsp_ready = (rsp_wt >= cfg_rsp_hold);
               if (!rsp_ready) rsp_wt++; else rsp_wt = 0;
            end else begin
               rsp_ready = 0; rsp_wt = 0;
            end
            aw_hs_f = awvalid && awready;
            if (aw_hs_f) last_awaddr = awaddr;
            w_hs_f = wvalid && wready;
            if (w_hs_f) begin last_wdata = wdata; last_wstrb = wstrb; end
            b_hs_f  = bvalid && bready;
            ar_hs_f = arvalid && arready;
            if (ar_hs_f) last_araddr = araddr;
            r_hs_f = rvalid && rready;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic reset_cfg();
      cfg_aw_delay = 0; cfg_w_delay = 0; cfg_ar_delay = 0; cfg_r_delay = 0;
      cfg_rsp_hold = 0; cfg_bresp = 0; cfg_rresp = 0; cfg_rdata_def = '0;
      rdq.delete();
   endtask

   task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [DW-1:0] mask,
                        input logic [DW-1:0] exp_data, input logic [1:0] exp_st,
                        input int lat, input string name);
      exp_t e;
      int   n;
      int   i;
      bit   acc;
      e.data = exp_data; e.status = exp_st; e.lat = lat; e.name = name;
      exp_q.push_back(e);
      n = rsp_cnt;
      @(negedge clk);
      cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
      acc = 0;
      i   = 0;
      while (!acc && i < 50) begin
         if (cmd_ready) begin
            acc        = 1;
            accept_cyc = cyc;
         end else begin
            @(negedge clk);
            i++;
         end
      end
      @(negedge clk);
      cmd_valid = 0;
      if (!acc) begin
         tests++; fails++;
         $display("FAIL %s_accept: got cmd_ready 0 for 50 cycles, expected 1", name);
      end
      i = 0;
      while (rsp_cnt == n && i < 2000) begin
         @(negedge clk);
         i++;
      end
      if (rsp_cnt == n) begin
         tests++; fails++;
         $display("FAIL %s_timeout: got no response in 2000 cycles, expected one", name);
         exp_q.delete();
      end
   endtask

   int n0, n1, n2;
   int k;

   initial begin
      cmd_valid = 0; cmd_op = 0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
      #23 rst = 0;
      @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      check("rst_rsp_status", 64'(rsp_status), 64'd0);
      check("rst_awvalid", 64'(awvalid), 64'd0);
      check("rst_wvalid", 64'(wvalid), 64'd0);
      check("rst_bready", 64'(bready), 64'd0);
      check("rst_arvalid", 64'(arvalid), 64'd0);
      check("rst_rready", 64'(rready), 64'd0);

      // Zero-wait write
      reset_cfg();
      n0 = aw_count; n1 = w_count; n2 = b_count;
      issue(2'd0, 32'h4, 32'h0, 32'h0, 32'h0, 2'd0, 3, "wr0");
      check("wr0_aw_count", 64'(aw_count - n0), 64'd1);
      check("wr0_w_count", 64'(w_count - n1), 64'd1);
      check("wr0_b_count", 64'(b_count - n2), 64'd1);
      check("wr0_awaddr", 64'(last_awaddr), 64'h4);
      check("wr0_wdata", 64'(last_wdata), 64'h0);
      check("wr0_wstrb", 64'(last_wstrb), 64'hF);
      check("wr0_awprot", 64'(awprot), 64'd0);

      // Read, slow slave, response back-pressured for 4 cycles
      reset_cfg();
      cfg_r_delay = 5; cfg_rsp_hold = 4; rdq.push_back(32'h3);
      n0 = ar_count;
      issue(2'd1, 32'h100, 32'h0, 32'h0, 32'h3, 2'd0, -1, "rd_slow");
      check("rd_slow_ar_count", 64'(ar_count - n0), 64'd1);
      check("rd_slow_araddr", 64'(last_araddr), 64'h100);
      check("rd_slow_hold_len", 64'(hold_len), 64'd5);

      // Zero-wait read
      reset_cfg();
      rdq.push_back(32'hDEAD_BEEF);
      issue(2'd1, 32'h8, 32'h0, 32'h0, 32'hDEAD_BEEF, 2'd0, 3, "rd_fast");
      check("rd_fast_arprot", 64'(arprot), 64'd0);

      // Poll matches on third read
      reset_cfg();
      rdq.push_back(32'h0); rdq.push_back(32'h1); rdq.push_back(32'h3);
      n0 = ar_count; gap_armed = 0; min_ar_gap = 1000;
      issue(2'd2, 32'h100, 32'h3, 32'h3, 32'h3, 2'd0, -1, "poll_match");
      check("poll_match_ar_count", 64'(ar_count - n0), 64'd3);
      check("poll_match_interval", 64'(min_ar_gap >= PI + 2), 64'd1);

      // Poll never matches: times out after PMT reads
      reset_cfg();
      n0 = ar_count;
      issue(2'd2, 32'h100, 32'h1, 32'h1, 32'h0, 2'd2, -1, "poll_tmo");
      check("poll_tmo_ar_count", 64'(ar_count - n0), 64'(PMT));

      // Write, AW accepted 3 cycles after W, slave error
      reset_cfg();
      cfg_aw_delay = 3; cfg_bresp = 2'd2;
      n0 = aw_count; n1 = w_count; n2 = b_count;
      issue(2'd0, 32'h10, 32'h1, 32'h0, 32'h0, 2'd1, -1, "wr_aw_late");
      check("wr_aw_late_aw", 64'(aw_count - n0), 64'd1);
      check("wr_aw_late_w", 64'(w_count - n1), 64'd1);
      check("wr_aw_late_b", 64'(b_count - n2), 64'd1);
      check("wr_aw_late_wdata", 64'(last_wdata), 64'h1);

      // Write, W accepted 3 cycles after AW, slave error
      reset_cfg();
      cfg_w_delay = 3; cfg_bresp = 2'd2;
      n0 = aw_count; n1 = w_count; n2 = b_count;
      issue(2'd0, 32'h14, 32'hA5, 32'h0, 32'h0, 2'd1, -1, "wr_w_late");
      check("wr_w_late_aw", 64'(aw_count - n0), 64'd1);
      check("wr_w_late_w", 64'(w_count - n1), 64'd1);
      check("wr_w_late_b", 64'(b_count - n2), 64'd1);
      check("wr_w_late_awaddr", 64'(last_awaddr), 64'h14);

      // Zero mask matches on first read
      reset_cfg();
      rdq.push_back(32'h55);
      n0 = ar_count;
      issue(2'd2, 32'h20, 32'hFF, 32'h0, 32'h55, 2'd0, -1, "poll_mask0");
      check("poll_mask0_ar_count", 64'(ar_count - n0), 64'd1);

      // Read with slave error
      reset_cfg();
      cfg_rresp = 2'd2; rdq.push_back(32'h77);
      issue(2'd1, 32'h24, 32'h0, 32'h0, 32'h77, 2'd1, 3, "rd_err");

      // Poll with slave error stops immediately
      reset_cfg();
      cfg_rresp = 2'd3; rdq.push_back(32'h9);
      n0 = ar_count;
      issue(2'd2, 32'h28, 32'h1, 32'hF, 32'h9, 2'd1, -1, "poll_err");
      check("poll_err_ar_count", 64'(ar_count - n0), 64'd1);

      // Reserved op behaves as a read
      reset_cfg();
      rdq.push_back(32'h12);
      n0 = ar_count; n1 = aw_count;
      issue(2'd3, 32'hC, 32'h0, 32'h0, 32'h12, 2'd0, 3, "rd_op3");
      check("rd_op3_ar_count", 64'(ar_count - n0), 64'd1);
      check("rd_op3_aw_count", 64'(aw_count - n1), 64'd0);

      // Reset while waiting for read data
      reset_cfg();
      cfg_r_delay = 20;
      n0 = rsp_cnt;
      @(negedge clk);
      cmd_valid = 1; cmd_op = 2'd1; cmd_addr = 32'h200;
      @(negedge clk);
      cmd_valid = 0;
      k = 0;
      while (!rready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("rst_mid_reached_rd_data", 64'(rready), 64'd1);
      #2 rst = 1;
      #1;
      check("rst_mid_arvalid", 64'(arvalid), 64'd0);
      check("rst_mid_rready", 64'(rready), 64'd0);
      check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
      repeat (3) @(negedge clk);
      #2 rst = 0;
      reset_cfg();
      @(negedge clk);
      check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
      repeat (25) @(negedge clk);
      check("rst_mid_no_rsp", 64'(rsp_cnt - n0), 64'd0);

      // Normal read after the aborted one
      rdq.push_back(32'h5A5A);
      n0 = ar_count;
      issue(2'd1, 32'h100, 32'h0, 32'h0, 32'h5A5A, 2'd0, 3, "rd_after_rst");
      check("rd_after_rst_ar_count", 64'(ar_count - n0), 64'd1);
      check("rd_after_rst_araddr", 64'(last_araddr), 64'h100);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pspin_ctrl_axil_master.md
Name: pspin_ctrl_axil_master

Overview:
- AXI-Lite initiator that sequences accesses to the PsPIN control register file: fetch enable, cluster reset, eoc/busy/MPQ status and the stdout FIFO.
- Accepts single commands (write, read, poll-until-match) on a valid/ready command port and turns each into AXI-Lite transactions.
- Returns one response per command on a valid/ready response port.
- Sits between the on-chip boot/management sequencer and the control register slave, in the same clock domain as that slave.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width.
- DATA_WIDTH, 32, AXI-Lite data width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- POLL_INTERVAL, 16, idle cycles between consecutive poll reads; must be >= 1.
- POLL_MAX_TRIES, 1024, maximum reads per poll command; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  0=write, 1=read, 2=poll, 3=reserved (treated as read)
- cmd_addr  in  ADDR_WIDTH  register byte address
- cmd_data  in  DATA_WIDTH  write data (write) / compare value (poll)
- cmd_mask  in  DATA_WIDTH  compare mask (poll only)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  DATA_WIDTH  read data; last read data for poll; 0 for write
- rsp_status  out  2  0=OKAY, 1=SLVERR (any nonzero bresp/rresp), 2=TIMEOUT
- m_axil_aw*/w*/b*/ar*/r*  AXI-Lite master channels, widths per parameters; awprot=arprot=3'b000; wstrb all ones

Behaviour:
- Reset: state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_status=0; awvalid=wvalid=bready=arvalid=rready=0; poll counters=0.
- One command outstanding at a time. cmd_ready=1 only in IDLE. Command fields are latched on acceptance.
- States:
  - IDLE
  - WR: awvalid and wvalid asserted together the cycle after acceptance. Each drops independently on its own handshake; either channel may complete first, or both in the same cycle.
  - WR_RESP: bready=1 until the B handshake.
  - RD_ADDR: arvalid until the AR handshake.
  - RD_DATA: rready=1 until the R handshake.
  - POLL_WAIT: counts POLL_INTERVAL cycles, then returns to RD_ADDR.
  - RESP: rsp_valid held with stable data/status until rsp_ready, then IDLE.
- Write path: IDLE -> WR -> WR_RESP -> RESP. status = (bresp!=0) ? 1 : 0; rsp_data=0.
- Read path: IDLE -> RD_ADDR -> RD_DATA -> RESP. rsp_data=rdata; status = (rresp!=0) ? 1 : 0.
- Poll path:
  - After each R handshake, try counter increments.
  - rresp!=0 -> RESP with status 1.
  - else (rdata & mask) == (cmd_data & mask) -> RESP with status 0.
  - else try count == POLL_MAX_TRIES -> RESP with status 2.
  - else -> POLL_WAIT.
  - rsp_data is always the last rdata.
  - Mask 0 matches on the first read.
- Minimum latency, zero-wait-state slave: accept at cycle 0; AR or AW/W valid at cycle 1; rsp_valid at cycle 3 for a read or write.
- rsp_valid asserts one cycle after the final B/R handshake.
- An AXI valid, once asserted, is never withdrawn before its handshake.
- Counters saturate; the try counter is ceil(log2(POLL_MAX_TRIES+1)) bits.
- Reset mid-transaction: all valids drop immediately, the in-flight command is discarded with no response, and the state returns to IDLE.

Test Plan:
- Write cmd addr 0x0004 data 0x0 -> one AW (0x4) and one W (data 0x0, strb 0xF); slave bresp=0 -> rsp_status 0, rsp_data 0x0.
- Read cmd addr 0x0100; slave returns rdata 0x3 after 5 wait cycles -> exactly one AR; rsp_data 0x3, status 0; rsp held for 4 cycles with rsp_ready=0, then accepted.
- Poll addr 0x0100, mask 0x3, value 0x3; slave returns 0x0, 0x1, 0x3 -> 3 ARs, each separated by >= POLL_INTERVAL idle cycles; rsp_data 0x3, status 0.
- Poll with POLL_MAX_TRIES=4 against a constant rdata 0x0, value 0x1, mask 0x1 -> exactly 4 ARs; rsp_status 2, rsp_data 0x0.
- Write with slave awready delayed 3 cycles after wready (and the reverse order) -> single B accepted; bresp=2 -> rsp_status 1.
- Assert rst while in RD_DATA -> arvalid/rready=0 immediately, no rsp_valid, cmd_ready=1 after reset release; a subsequent read completes normally.
